clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time controller for the 100 MHz-derived divided clock. It owns the divider counter,
//  accepts new divide ratios over a valid/ready handshake and applies them glitch-free at a
//  period boundary. It starts and stops the divided clock cleanly on request (no runt pulses).
//  Feeds downstream logic with clk_out, plus a tick clock-enable pulse for logic kept on clk_100mhz.
// PARAMETERS
//  DIV_W         16  width of half-period count H and related ports
//  DEFAULT_HALF  5   H after reset (5 -> 100 MHz/10 = 10 MHz)
// PORTS
//  clk_100mhz   in   1      sole clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  en           in   1      run request (level)
//  cfg_valid    in   1      new H offered
//  cfg_half     in   DIV_W  offered half-period H (clk_100mhz cycles per clk_out phase)
//  cfg_ready    out  1      controller can accept cfg
//  clk_out      out  1      divided clock, registered, period 2*H, 50% duty
//  tick         out  1      1-cycle pulse coincident with first high cycle of clk_out
//  busy         out  1      1 in RUN/UPD/STOP
//  cfg_err      out  1      1-cycle pulse: cfg_half==0 rejected
//  half_active  out  DIV_W  H currently in effect
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, counter=0, clk_out=0, tick=0, cfg_err=0,
//   half_active=DEFAULT_HALF, pending discarded. Reset has priority in any state.
//  States: IDLE, RUN, UPD (RUN with pending H), STOP (draining high phase).
//  Counter, in RUN/UPD/STOP only: counter==H-1 -> counter<=0, clk_out<=~clk_out;
//   else counter<=counter+1. H=half_active. H=1 toggles every cycle.
//  tick<=1 on the cycle clk_out goes 0->1, else 0.
//  IDLE: clk_out=0, counter=0. en=1 -> RUN next cycle. clk_out first rises after H RUN cycles.
//  cfg_ready = (state==IDLE) | (state==RUN & en). Combinational from state and en.
//  Transfer = cfg_valid & cfg_ready.
//   cfg_half==0: discarded, cfg_err=1 next cycle, state and half_active unchanged.
//   IDLE transfer: half_active<=cfg_half next cycle.
//   RUN transfer: pending<=cfg_half, state->UPD.
//   If the same cycle also starts RUN from IDLE, the new H takes effect before the first phase.
//  UPD: on the 1->0 toggle of clk_out, half_active<=pending, counter<=0, state->RUN.
//   The following low phase uses the new H. No toggle is produced early or late.
//  RUN/UPD with en=0 -> STOP. A pending value from UPD is kept.
//  STOP: clk_out==0 -> IDLE next cycle. clk_out==1 -> keep counting until the 1->0 toggle, then IDLE.
//   On entering IDLE, half_active<=pending if one exists.
//  en re-asserted during STOP is ignored until IDLE is reached.
//  busy = (state!=IDLE). clk_out is never driven from combinational logic.
//  Counter width DIV_W; counter never exceeds H-1 because H changes only at a toggle with counter=0.
// TESTING
//  T1 reset, en=1 held, H=5: clk_out rises 6 cycles after en sampled.
//     Then period 10, high 5 / low 5. tick every 10 cycles, busy=1.
//  T2 IDLE, cfg_half=2 accepted, then en=1: half_active=2, period 4 cycles, duty 2/2.
//  T3 RUN H=5, cfg_half=3 sent 2 cycles into a high phase: cfg_ready=0 while in UPD.
//     High phase still lasts 5 cycles, then low 3 / high 3 repeating. half_active=3 at the fall.
//  T4 RUN H=4, en dropped 1 cycle into high: clk_out stays high for the remaining 3 cycles.
//     Then clk_out=0, IDLE, busy=0. Dropped during low: IDLE next cycle, clk_out=0.
//  T5 cfg_half=0 in IDLE and in RUN: cfg_err single pulse each time, half_active unchanged.
//  T6 rst=1 while in UPD with clk_out=1: next cycle clk_out=0, IDLE, half_active=5, pending gone.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Run-time divider for clk_100mhz: registered 50% clk_out of period 2*H, new H applied at a falling toggle.
// Outputs lag inputs by one cycle; cfg_ready drops while an update is pending or while stopping/disabled.
module clk_div_ctrl #(
  parameter int DIV_W        = 16,
  parameter int DEFAULT_HALF = 5
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err,
  output logic [DIV_W-1:0] half_active
);

  typedef enum logic [1:0] {IDLE, RUN, UPD, STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             take;
  logic             wrap;
  logic [DIV_W-1:0] cnt_step;

  assign cfg_ready = (state_q == IDLE) | ((state_q == RUN) & en);
  assign xfer      = cfg_valid & cfg_ready;
  assign take      = xfer & (cfg_half != '0);
  assign wrap      = (cnt_q == half_q - DIV_W'(1));
  assign cnt_step  = wrap ? '0 : cnt_q + DIV_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = xfer & (cfg_half == '0);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (take) half_d = cfg_half;
        if (en) state_d = RUN;
      end
      RUN, UPD: begin
        cnt_d = cnt_step;
        clk_d = clk_q ^ wrap;
        if (!en) begin
          state_d = STOP;
        end else if ((state_q == UPD) && wrap && clk_q) begin
          // counter restarts at 0 here, so the new H can never be undershot
          half_d     = pend_q;
          pend_vld_d = 1'b0;
          state_d    = RUN;
        end else if ((state_q == RUN) && take) begin
          pend_d     = cfg_half;
          pend_vld_d = 1'b1;
          state_d    = UPD;
        end
      end
      STOP: begin
        if (clk_q && !wrap) begin
          cnt_d = cnt_step;
        end else begin
          cnt_d   = '0;
          clk_d   = 1'b0;
          state_d = IDLE;
          if (pend_vld_q) begin
            half_d     = pend_q;
            pend_vld_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick_d = clk_d & ~clk_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= DIV_W'(DEFAULT_HALF);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick        = tick_q;
  assign cfg_err     = err_q;
  assign half_active = half_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: phase-countdown reference model checked every cycle,
// plus directed scenarios with hand-derived phase lengths and handshake outcomes.
module tb_clk_div_ctrl;

  localparam int DIV_W = 16;

  logic             clk_100mhz = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic             cfg_err;
  logic [DIV_W-1:0] half_active;

  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_HALF(5)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_half   (cfg_half),
    .cfg_ready  (cfg_ready),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .half_active(half_active)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 running (m_pv marks a pending H), 2 stopping.
  // Phase timing kept as cycles left before the next flip.
  int   m_mode, m_half, m_pend, m_left;
  logic m_clk, m_tick, m_err, m_pv;
  logic m_rdy, m_ok, m_old, m_flip;

  function automatic logic model_ready();
    return (m_mode == 0) || (m_mode == 1 && !m_pv && en);
  endfunction

  always @(posedge clk_100mhz) begin
    if (rst) begin
      m_mode = 0; m_half = 5; m_pend = 0; m_left = 0;
      m_clk = 1'b0; m_tick = 1'b0; m_err = 1'b0; m_pv = 1'b0;
    end else begin
      m_rdy = model_ready();
      m_ok  = cfg_valid && m_rdy && (cfg_half != 0);
      m_err = cfg_valid && m_rdy && (cfg_half == 0);
      m_old = m_clk;
      case (m_mode)
        0: begin
          if (m_ok) m_half = int'(cfg_half);
          if (en) begin
            m_mode = 1;
            m_left = m_half;
          end
        end
        1: begin
          m_left = m_left - 1;
          m_flip = (m_left == 0);
          if (m_flip) m_clk = !m_clk;
          if (!en) m_mode = 2;
          else if (m_flip && m_old && m_pv) begin
            m_half = m_pend;
            m_pv   = 1'b0;
          end else if (m_ok) begin
            m_pend = int'(cfg_half);
            m_pv   = 1'b1;
          end
          if (m_flip) m_left = m_half;
        end
        default: begin
          if (m_old) begin
            m_left = m_left - 1;
            if (m_left == 0) m_clk = 1'b0;
          end
          if (!m_clk) begin
            m_mode = 0;
            if (m_pv) begin
              m_half = m_pend;
              m_pv   = 1'b0;
            end
          end
        end
      endcase
      m_tick = m_clk && !m_old;
    end
  end

  always @(negedge clk_100mhz) begin
    if (chk_on) begin
      chk("m_clk_out", clk_out, m_clk);
      chk("m_tick", tick, m_tick);
      chk("m_busy", busy, m_mode != 0);
      chk("m_cfg_err", cfg_err, m_err);
      chk("m_half_active", half_active, m_half);
      chk("m_cfg_ready", cfg_ready, model_ready());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  // Count posedges until clk_out reaches lvl; returns budget on timeout.
  task automatic wait_level(input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk_100mhz);
      #1;
      n++;
    end while (clk_out !== lvl && n < budget);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    cyc(3);
    chk_on = 1'b1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_half", half_active, 5);
    chk("rst_ready", cfg_ready, 1);
    rst = 1'b0;

    // T1: default H=5
    en = 1'b1;
    wait_level(1'b1, 40, n); chk("t1_first_rise", n, 6);
    chk("t1_tick", tick, 1);
    chk("t1_busy", busy, 1);
    wait_level(1'b0, 40, n); chk("t1_high", n, 5);
    wait_level(1'b1, 40, n); chk("t1_low", n, 5);
    k = 0;
    repeat (20) begin
      cyc(1);
      if (tick) k++;
    end
    chk("t1_ticks_20cyc", k, 2);

    // drop en during low phase
    wait_level(1'b0, 40, n); chk("t1_high2", n, 5);
    en = 1'b0;
    cyc(1); chk("stoplow_busy1", busy, 1); chk("stoplow_clk1", clk_out, 0);
    cyc(1); chk("stoplow_busy2", busy, 0); chk("stoplow_clk2", clk_out, 0);

    // T2: H=2 loaded in IDLE
    cfg_valid = 1'b1; cfg_half = 16'd2;
    cyc(1); cfg_valid = 1'b0;
    chk("t2_half", half_active, 2);
    en = 1'b1;
    wait_level(1'b1, 40, n); chk("t2_first_rise", n, 3);
    wait_level(1'b0, 40, n); chk("t2_high", n, 2);
    wait_level(1'b1, 40, n); chk("t2_low", n, 2);

    // back to H=5 while running
    cfg_valid = 1'b1; cfg_half = 16'd5;
    chk("t3_ready_run", cfg_ready, 1);
    cyc(1); cfg_valid = 1'b0;
    wait_level(1'b0, 40, n); chk("t3_old_high", n, 1);
    chk("t3_half5", half_active, 5);
    wait_level(1'b1, 40, n); chk("t3_new_low5", n, 5);

    // T3: H=3 offered 2 cycles into a high phase
    cyc(1);
    cfg_valid = 1'b1; cfg_half = 16'd3;
    chk("t3_ready_before", cfg_ready, 1);
    cyc(1); cfg_valid = 1'b0;
    chk("t3_ready_upd", cfg_ready, 0);
    chk("t3_half_upd", half_active, 5);
    wait_level(1'b0, 40, n); chk("t3_high_rest", n, 3);
    chk("t3_half3", half_active, 3);
    wait_level(1'b1, 40, n); chk("t3_low3", n, 3);
    wait_level(1'b0, 40, n); chk("t3_high3", n, 3);
    chk("t3_ready_after", cfg_ready, 1);

    // T5: zero rejected while running
    cfg_valid = 1'b1; cfg_half = 16'd0;
    cyc(1); cfg_valid = 1'b0;
    chk("t5_run_err", cfg_err, 1);
    chk("t5_run_half", half_active, 3);
    chk("t5_run_ready", cfg_ready, 1);
    cyc(1); chk("t5_run_err_clr", cfg_err, 0);

    // T4: H=4, en dropped one cycle into high
    cfg_valid = 1'b1; cfg_half = 16'd4;
    cyc(1); cfg_valid = 1'b0;
    k = 0;
    while (half_active !== 16'd4 && k < 40) begin
      cyc(1);
      k++;
    end
    chk("t4_half4", half_active, 4);
    wait_level(1'b1, 40, n); chk("t4_low4", n, 4);
    cyc(1);
    en = 1'b0;
    wait_level(1'b0, 40, n); chk("t4_high_rest", n, 3);
    chk("t4_busy", busy, 0);
    chk("t4_ready", cfg_ready, 1);

    // T5: zero rejected in IDLE
    cfg_valid = 1'b1; cfg_half = 16'd0;
    cyc(1); cfg_valid = 1'b0;
    chk("t5_idle_err", cfg_err, 1);
    chk("t5_idle_half", half_active, 4);
    chk("t5_idle_busy", busy, 0);
    cyc(1); chk("t5_idle_err_clr", cfg_err, 0);

    // T6: reset while an update is pending during a high phase
    en = 1'b1;
    wait_level(1'b1, 40, n); chk("t6_first_rise", n, 5);
    cfg_valid = 1'b1; cfg_half = 16'd7;
    cyc(1); cfg_valid = 1'b0;
    chk("t6_ready_upd", cfg_ready, 0);
    chk("t6_clk_high", clk_out, 1);
    rst = 1'b1; en = 1'b0;
    cyc(1); rst = 1'b0;
    chk("t6_clk", clk_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_half", half_active, 5);
    chk("t6_ready", cfg_ready, 1);
    en = 1'b1;
    wait_level(1'b1, 40, n); chk("t6_rise_h5", n, 6);
    wait_level(1'b0, 40, n); chk("t6_high_h5", n, 5);
    en = 1'b0;
    cyc(2);
    chk("t6_idle", busy, 0);
    chk("t6_no_pending", half_active, 5);

    // new H and en together from IDLE
    cfg_valid = 1'b1; cfg_half = 16'd3; en = 1'b1;
    cyc(1); cfg_valid = 1'b0;
    chk("same_half", half_active, 3);
    wait_level(1'b1, 40, n); chk("same_first_rise", n, 3);

    // en dropped while an update is pending: applied on reaching IDLE
    cfg_valid = 1'b1; cfg_half = 16'd6;
    cyc(1); cfg_valid = 1'b0; en = 1'b0;
    wait_level(1'b0, 40, n); chk("stoppend_high_rest", n, 2);
    chk("stoppend_busy", busy, 0);
    chk("stoppend_half", half_active, 6);
    en = 1'b1;
    wait_level(1'b1, 40, n); chk("stoppend_rise_h6", n, 7);
    en = 1'b0;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
